// File: rtl/ddram_rom_arbiter.sv
// Serialises loader writes, ROM reads and backup-RAM accesses onto the single DDRAM port.
// Optional one-entry ROM read cache is enabled with `define DDRAM_ROM_CACHE_EN.
module ddram_rom_arbiter #(
    parameter logic [28:0] BASE_ADDR = 29'h0600000,
    parameter logic [21:0] BRAM_OFS  = 22'h3F0000
) (
    input  logic        clk_sys,
    input  logic        reset,

    input  logic [24:0] wr_addr,
    input  logic [15:0] wr_data,
    input  logic        wr_req,
    output logic        wr_ack,

    input  logic [24:0] rd_addr,
    input  logic        rd_req,
    output logic        rd_ack,
    output logic [63:0] rd_data,

    input  logic [18:0] bram_addr,
    input  logic [7:0]  bram_din,
    input  logic        bram_we,
    input  logic        bram_req,
    output logic        bram_ack,
    output logic [7:0]  bram_dout,

    input  logic        DDRAM_BUSY,
    output logic [7:0]  DDRAM_BURSTCNT,
    output logic [28:0] DDRAM_ADDR,
    input  logic [63:0] DDRAM_DOUT,
    input  logic        DDRAM_DOUT_READY,
    output logic        DDRAM_RD,
    output logic [63:0] DDRAM_DIN,
    output logic [7:0]  DDRAM_BE,
    output logic        DDRAM_WE
);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_RWAIT, S_DRAIN} state_t;
    typedef enum logic [1:0] {C_WR, C_ROM, C_BRAM} cli_t;

    state_t      r_state;
    cli_t        r_cli;
    logic        r_last_rd;
    logic [2:0]  r_bram_lane;
    logic        r_wr_ack, r_rd_ack, r_bram_ack;
    logic [63:0] r_rd_data;
    logic [7:0]  r_bram_dout;
    logic        r_ddr_rd, r_ddr_we;
    logic [28:0] r_ddr_addr;
    logic [63:0] r_ddr_din;
    logic [7:0]  r_ddr_be;

    logic        w_wr_pend, w_rd_pend, w_bram_pend;
    logic        w_grant_rd, w_grant_bram;
    logic        w_rd_hit;
    logic [63:0] w_cache_word;
    logic [28:0] w_ldr_addr, w_rom_addr, w_bram_addr;
    logic        w_unused;

    assign w_wr_pend   = wr_req   ^ r_wr_ack;
    assign w_rd_pend   = rd_req   ^ r_rd_ack;
    assign w_bram_pend = bram_req ^ r_bram_ack;

    // On a rd/bram tie the client granted last time yields.
    assign w_grant_rd   = w_rd_pend && (!w_bram_pend || !r_last_rd);
    assign w_grant_bram = w_bram_pend && !w_grant_rd;

    assign w_ldr_addr  = BASE_ADDR + {7'd0, wr_addr[24:3]};
    assign w_rom_addr  = BASE_ADDR + {7'd0, rd_addr[24:3]};
    assign w_bram_addr = BASE_ADDR + {7'd0, BRAM_OFS} + {13'd0, bram_addr[18:3]};

    assign w_unused = ^{wr_addr[0], rd_addr[2:0]};

`ifdef DDRAM_ROM_CACHE_EN
    logic        r_cache_vld;
    logic [21:0] r_cache_tag;
    logic [63:0] r_cache_data;

    assign w_rd_hit     = r_cache_vld && (r_cache_tag == rd_addr[24:3]);
    assign w_cache_word = r_cache_data;

    // Tag is loaded when the miss is issued; valid is raised only once the word returns.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_cache_vld <= 1'b0;
        end else if (r_state == S_IDLE && w_wr_pend) begin
            r_cache_vld <= 1'b0;
        end else if (r_state == S_IDLE && w_grant_rd && !w_rd_hit) begin
            r_cache_vld <= 1'b0;
            r_cache_tag <= rd_addr[24:3];
        end else if (r_state == S_RWAIT && DDRAM_DOUT_READY && r_cli == C_ROM) begin
            r_cache_vld  <= 1'b1;
            r_cache_data <= DDRAM_DOUT;
        end
    end
`else
    assign w_rd_hit     = 1'b0;
    assign w_cache_word = 64'd0;
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_wr_ack    <= wr_req;
            r_rd_ack    <= rd_req;
            r_bram_ack  <= bram_req;
            r_ddr_rd    <= 1'b0;
            r_ddr_we    <= 1'b0;
            r_ddr_be    <= 8'd0;
            r_ddr_addr  <= 29'd0;
            r_ddr_din   <= 64'd0;
            r_rd_data   <= 64'd0;
            r_bram_dout <= 8'd0;
            r_last_rd   <= 1'b0;
            r_cli       <= C_WR;
            r_bram_lane <= 3'd0;
            // A read already accepted by DDRAM still owes one DOUT_READY.
            case (r_state)
                S_RD:    r_state <= DDRAM_BUSY ? S_IDLE : S_DRAIN;
                S_RWAIT: r_state <= DDRAM_DOUT_READY ? S_IDLE : S_DRAIN;
                S_DRAIN: r_state <= DDRAM_DOUT_READY ? S_IDLE : S_DRAIN;
                default: r_state <= S_IDLE;
            endcase
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_wr_pend) begin
                        r_cli      <= C_WR;
                        r_ddr_we   <= 1'b1;
                        r_ddr_addr <= w_ldr_addr;
                        r_ddr_din  <= {4{wr_data}};
                        r_ddr_be   <= 8'b0000_0011 << {wr_addr[2:1], 1'b0};
                        r_state    <= S_WR;
                    end else if (w_grant_rd) begin
                        r_last_rd <= 1'b1;
                        if (w_rd_hit) begin
                            r_rd_data <= w_cache_word;
                            r_rd_ack  <= rd_req;
                        end else begin
                            r_cli      <= C_ROM;
                            r_ddr_rd   <= 1'b1;
                            r_ddr_addr <= w_rom_addr;
                            r_ddr_be   <= 8'hFF;
                            r_state    <= S_RD;
                        end
                    end else if (w_grant_bram) begin
                        r_last_rd   <= 1'b0;
                        r_cli       <= C_BRAM;
                        r_bram_lane <= bram_addr[2:0];
                        r_ddr_addr  <= w_bram_addr;
                        if (bram_we) begin
                            r_ddr_we  <= 1'b1;
                            r_ddr_din <= {8{bram_din}};
                            r_ddr_be  <= 8'b0000_0001 << bram_addr[2:0];
                            r_state   <= S_WR;
                        end else begin
                            r_ddr_rd <= 1'b1;
                            r_ddr_be <= 8'hFF;
                            r_state  <= S_RD;
                        end
                    end
                end
                S_WR: begin
                    if (!DDRAM_BUSY) begin
                        r_ddr_we <= 1'b0;
                        r_state  <= S_IDLE;
                        if (r_cli == C_BRAM) r_bram_ack <= bram_req;
                        else                 r_wr_ack   <= wr_req;
                    end
                end
                S_RD: begin
                    if (!DDRAM_BUSY) begin
                        r_ddr_rd <= 1'b0;
                        r_state  <= S_RWAIT;
                    end
                end
                S_RWAIT: begin
                    if (DDRAM_DOUT_READY) begin
                        r_state <= S_IDLE;
                        if (r_cli == C_BRAM) begin
                            r_bram_dout <= DDRAM_DOUT[{r_bram_lane, 3'b000} +: 8];
                            r_bram_ack  <= bram_req;
                        end else begin
                            r_rd_data <= DDRAM_DOUT;
                            r_rd_ack  <= rd_req;
                        end
                    end
                end
                S_DRAIN: begin
                    if (DDRAM_DOUT_READY) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign wr_ack         = r_wr_ack;
    assign rd_ack         = r_rd_ack;
    assign bram_ack       = r_bram_ack;
    assign rd_data        = r_rd_data;
    assign bram_dout      = r_bram_dout;
    assign DDRAM_BURSTCNT = 8'd1;
    assign DDRAM_ADDR     = r_ddr_addr;
    assign DDRAM_RD       = r_ddr_rd;
    assign DDRAM_WE       = r_ddr_we;
    assign DDRAM_DIN      = r_ddr_din;
    assign DDRAM_BE       = r_ddr_be;

endmodule

// File: tb/tb_ddram_rom_arbiter.sv
// Directed bench for ddram_rom_arbiter; DDRAM side is driven by hand from the stimulus.
module tb_ddram_rom_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [24:0] wr_addr, rd_addr;
    logic [15:0] wr_data;
    logic        wr_req, wr_ack, rd_req, rd_ack;
    logic [63:0] rd_data;
    logic [18:0] bram_addr;
    logic [7:0]  bram_din, bram_dout;
    logic        bram_we, bram_req, bram_ack;
    logic        DDRAM_BUSY, DDRAM_DOUT_READY, DDRAM_RD, DDRAM_WE;
    logic [7:0]  DDRAM_BURSTCNT, DDRAM_BE;
    logic [28:0] DDRAM_ADDR;
    logic [63:0] DDRAM_DOUT, DDRAM_DIN;

    int n_tests = 0;
    int n_fail  = 0;

    // Log of accepted DDRAM commands: {is_write, address}
    logic [29:0] cmd_q[$];
    int          rd_acc_cnt = 0;

    always #5 clk_sys = ~clk_sys;

    ddram_rom_arbiter dut (
        .clk_sys(clk_sys), .reset(reset),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_req(wr_req), .wr_ack(wr_ack),
        .rd_addr(rd_addr), .rd_req(rd_req), .rd_ack(rd_ack), .rd_data(rd_data),
        .bram_addr(bram_addr), .bram_din(bram_din), .bram_we(bram_we),
        .bram_req(bram_req), .bram_ack(bram_ack), .bram_dout(bram_dout),
        .DDRAM_BUSY(DDRAM_BUSY), .DDRAM_BURSTCNT(DDRAM_BURSTCNT), .DDRAM_ADDR(DDRAM_ADDR),
        .DDRAM_DOUT(DDRAM_DOUT), .DDRAM_DOUT_READY(DDRAM_DOUT_READY), .DDRAM_RD(DDRAM_RD),
        .DDRAM_DIN(DDRAM_DIN), .DDRAM_BE(DDRAM_BE), .DDRAM_WE(DDRAM_WE)
    );

    always @(posedge clk_sys) begin
        if (!reset && DDRAM_WE && !DDRAM_BUSY) cmd_q.push_back({1'b1, DDRAM_ADDR});
        if (!reset && DDRAM_RD && !DDRAM_BUSY) begin
            cmd_q.push_back({1'b0, DDRAM_ADDR});
            rd_acc_cnt <= rd_acc_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic serve_read(input logic [63:0] data);
        DDRAM_DOUT       = data;
        DDRAM_DOUT_READY = 1'b1;
        step();
        DDRAM_DOUT_READY = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base_q, base_rd, served, cyc;
        logic wr_t, rd_t, bram_t;

        reset = 1'b1;
        wr_addr = '0; wr_data = '0; wr_req = 1'b1;
        rd_addr = '0; rd_req = 1'b0;
        bram_addr = '0; bram_din = '0; bram_we = 1'b0; bram_req = 1'b0;
        DDRAM_BUSY = 1'b0; DDRAM_DOUT = '0; DDRAM_DOUT_READY = 1'b0;
        step(); step();
        reset = 1'b0;

        chk("rst_wr_ack", {63'd0, wr_ack}, 64'd1);
        chk("rst_rd_ack", {63'd0, rd_ack}, 64'd0);
        chk("rst_strobes", {62'd0, DDRAM_RD, DDRAM_WE}, 64'd0);
        chk("rst_be", {56'd0, DDRAM_BE}, 64'd0);
        chk("rst_addr", {35'd0, DDRAM_ADDR}, 64'd0);
        chk("rst_din", DDRAM_DIN, 64'd0);
        chk("rst_rd_data", rd_data, 64'd0);
        chk("rst_bram_dout", {56'd0, bram_dout}, 64'd0);
        chk("burstcnt", {56'd0, DDRAM_BURSTCNT}, 64'd1);
        step();
        chk("rst_no_we", {63'd0, DDRAM_WE}, 64'd0);

        // Loader write
        wr_addr = 25'h000006; wr_data = 16'hA55A; wr_req = ~wr_req;
        step();
        chk("wr_we", {63'd0, DDRAM_WE}, 64'd1);
        chk("wr_addr", {35'd0, DDRAM_ADDR}, 64'h0600000);
        chk("wr_be", {56'd0, DDRAM_BE}, 64'hC0);
        chk("wr_din", DDRAM_DIN, 64'hA55AA55AA55AA55A);
        chk("wr_ack_early", {63'd0, wr_ack}, {63'd0, ~wr_req});
        step();
        chk("wr_we_drop", {63'd0, DDRAM_WE}, 64'd0);
        chk("wr_ack", {63'd0, wr_ack}, {63'd0, wr_req});

        // ROM read with BUSY held
        DDRAM_BUSY = 1'b1;
        rd_addr = 25'h000010; rd_req = ~rd_req;
        step();
        chk("rd_rd_c0", {63'd0, DDRAM_RD}, 64'd1);
        chk("rd_be", {56'd0, DDRAM_BE}, 64'hFF);
        for (int i = 1; i < 4; i++) begin
            step();
            chk($sformatf("rd_hold_rd_c%0d", i), {63'd0, DDRAM_RD}, 64'd1);
            chk($sformatf("rd_hold_addr_c%0d", i), {35'd0, DDRAM_ADDR}, 64'h0600002);
        end
        DDRAM_BUSY = 1'b0;
        step();
        chk("rd_rd_drop", {63'd0, DDRAM_RD}, 64'd0);
        step();
        chk("rd_ack_wait", {63'd0, rd_ack}, {63'd0, ~rd_req});
        serve_read(64'h0123456789ABCDEF);
        chk("rd_data", rd_data, 64'h0123456789ABCDEF);
        chk("rd_ack", {63'd0, rd_ack}, {63'd0, rd_req});

        // Backup-RAM write then read of the same byte
        bram_addr = 19'h00005; bram_din = 8'h3C; bram_we = 1'b1; bram_req = ~bram_req;
        step();
        chk("bw_we", {63'd0, DDRAM_WE}, 64'd1);
        chk("bw_addr", {35'd0, DDRAM_ADDR}, 64'h09F0000);
        chk("bw_be", {56'd0, DDRAM_BE}, 64'h20);
        chk("bw_din", DDRAM_DIN, 64'h3C3C3C3C3C3C3C3C);
        step();
        chk("bw_ack", {63'd0, bram_ack}, {63'd0, bram_req});
        bram_we = 1'b0; bram_req = ~bram_req;
        step();
        chk("br_rd", {63'd0, DDRAM_RD}, 64'd1);
        chk("br_addr", {35'd0, DDRAM_ADDR}, 64'h09F0000);
        step();
        serve_read(64'h0000_3C00_0000_0000);
        chk("br_dout", {56'd0, bram_dout}, 64'h3C);
        chk("br_ack", {63'd0, bram_ack}, {63'd0, bram_req});

        // All three clients toggle together
        base_q = cmd_q.size();
        served = rd_acc_cnt;
        wr_addr = 25'h000020; wr_data = 16'h1234;
        rd_addr = 25'h000040;
        bram_addr = 19'h00010; bram_din = 8'h77; bram_we = 1'b1;
        wr_req = ~wr_req; rd_req = ~rd_req; bram_req = ~bram_req;
        wr_t = wr_ack; rd_t = rd_ack; bram_t = bram_ack;
        cyc = 0;
        while (cyc < 40 && !(wr_ack == wr_req && rd_ack == rd_req && bram_ack == bram_req)) begin
            DDRAM_DOUT = 64'hCAFEF00D_DEADBEEF;
            DDRAM_DOUT_READY = (rd_acc_cnt > served);
            if (rd_acc_cnt > served) served++;
            step();
            DDRAM_DOUT_READY = 1'b0;
            cyc++;
        end
        step();
        chk("all_wr_ack", {63'd0, wr_ack}, {63'd0, ~wr_t});
        chk("all_rd_ack", {63'd0, rd_ack}, {63'd0, ~rd_t});
        chk("all_bram_ack", {63'd0, bram_ack}, {63'd0, ~bram_t});
        chk("all_ncmd", 64'(cmd_q.size() - base_q), 64'd3);
        if (cmd_q.size() >= base_q + 3) begin
            chk("all_cmd0", {34'd0, cmd_q[base_q]},     {34'd0, 1'b1, 29'h0600004});
            chk("all_cmd1", {34'd0, cmd_q[base_q + 1]}, {34'd0, 1'b0, 29'h0600008});
            chk("all_cmd2", {34'd0, cmd_q[base_q + 2]}, {34'd0, 1'b1, 29'h09F0002});
        end
        chk("all_rd_data", rd_data, 64'hCAFEF00D_DEADBEEF);

        // Reset while waiting for read data
        rd_addr = 25'h000018; rd_req = ~rd_req;
        step();
        chk("rw_rd", {35'd0, DDRAM_ADDR}, 64'h0600003);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rw_ack_dropped", {63'd0, rd_ack}, {63'd0, rd_req});
        chk("rw_data_reset", rd_data, 64'd0);
        rd_addr = 25'h000028; rd_req = ~rd_req;
        step();
        chk("drain_no_rd", {63'd0, DDRAM_RD}, 64'd0);
        serve_read(64'hBADBADBADBADBAD0);
        chk("drain_data", rd_data, 64'd0);
        chk("drain_no_ack", {63'd0, rd_ack}, {63'd0, ~rd_req});
        step();
        chk("post_rd", {63'd0, DDRAM_RD}, 64'd1);
        chk("post_addr", {35'd0, DDRAM_ADDR}, 64'h0600005);
        step();
        serve_read(64'h1122334455667788);
        chk("post_data", rd_data, 64'h1122334455667788);
        chk("post_ack", {63'd0, rd_ack}, {63'd0, rd_req});

        // Repeat reads of one word, with a loader write in between
        base_rd = rd_acc_cnt;
        rd_addr = 25'h000100; rd_req = ~rd_req;
        step(); step();
        serve_read(64'h5555AAAA5555AAAA);
        chk("c1_data", rd_data, 64'h5555AAAA5555AAAA);
        rd_req = ~rd_req;
`ifdef DDRAM_ROM_CACHE_EN
        step();
        chk("c2_hit_ack", {63'd0, rd_ack}, {63'd0, rd_req});
        chk("c2_hit_data", rd_data, 64'h5555AAAA5555AAAA);
        chk("c2_no_rd", 64'(rd_acc_cnt - base_rd), 64'd1);
`else
        step(); step();
        serve_read(64'h5555AAAA5555AAAA);
        chk("c2_ack", {63'd0, rd_ack}, {63'd0, rd_req});
        chk("c2_rd_again", 64'(rd_acc_cnt - base_rd), 64'd2);
`endif
        wr_addr = 25'h000100; wr_data = 16'h0F0F; wr_req = ~wr_req;
        step(); step();
        chk("c_wr_ack", {63'd0, wr_ack}, {63'd0, wr_req});
        rd_req = ~rd_req;
        step();
        chk("c3_rd", {63'd0, DDRAM_RD}, 64'd1);
        step();
        serve_read(64'h0F0F0F0F0F0F0F0F);
        chk("c3_data", rd_data, 64'h0F0F0F0F0F0F0F0F);
        chk("c3_ack", {63'd0, rd_ack}, {63'd0, rd_req});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
